countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 100 ++++++++++
 tb/tb_countdown_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown timer with prescaler, pause, one-shot/auto-reload and
// warn/expiry flags. All outputs are registered.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int WIDTH         = 5,
    parameter int WARN_LEVEL    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] timeleft,
    output logic             running,
    output logic             warn,
    output logic             end_f,
    output logic             expired
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] reload_val;

    function automatic logic warn_of(input logic [WIDTH-1:0] v);
        return (v != '0) && (32'(v) <= WARN_LEVEL);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            reload_val <= '0;
            timeleft   <= '0;
            running    <= 1'b0;
            warn       <= 1'b0;
            end_f      <= 1'b0;
            expired    <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                timeleft   <= load_value;
                reload_val <= load_value;
                presc      <= '0;
                if (load_value != '0) begin
                    state   <= RUN;
                    running <= 1'b1;
                    end_f   <= 1'b0;
                    warn    <= warn_of(load_value);
                end else begin
                    state   <= DONE;
                    running <= 1'b0;
                    end_f   <= 1'b1;
                    warn    <= 1'b0;
                    expired <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        // A completing tick still takes effect when pause rises on the same edge
                        if (pause)
                            state <= PAUSED;
                        if (presc == LAST) begin
                            presc <= '0;
                            if (timeleft <= WIDTH'(1)) begin
                                expired <= 1'b1;
                                if (reload_mode) begin
                                    timeleft <= reload_val;
                                    warn     <= warn_of(reload_val);
                                end else begin
                                    timeleft <= '0;
                                    state    <= DONE;
                                    running  <= 1'b0;
                                    warn     <= 1'b0;
                                    end_f    <= 1'b1;
                                end
                            end else begin
                                timeleft <= timeleft - WIDTH'(1);
                                warn     <= warn_of(timeleft - WIDTH'(1));
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    PAUSED: begin
                        if (!pause)
                            state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4, WIDTH=5, WARN_LEVEL=3.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [4:0] load_value;
    logic       pause;
    logic       reload_mode;
    logic [4:0] timeleft;
    logic       running, warn, end_f, expired;

    int total = 0;
    int bad   = 0;

    countdown_timer #(.TICKS_PER_SEC(4), .WIDTH(5), .WARN_LEVEL(3)) dut (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .pause(pause), .reload_mode(reload_mode), .timeleft(timeleft),
        .running(running), .warn(warn), .end_f(end_f), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a load sampled at "edge 0"; returns just after that edge
    task automatic do_load(input logic [4:0] v, input logic rm);
        load_value = v; reload_mode = rm; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; load_value = '0; pause = 1'b0; reload_mode = 1'b0;
        step(); step();
        total++;
        if ({timeleft, running, warn, end_f, expired} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs got tl=%0d run=%b warn=%b end=%b exp=%b want all 0",
                     timeleft, running, warn, end_f, expired);
        end
        rst = 1'b0;
        step();
        total++;
        if ({timeleft, running, end_f} !== 7'b0) begin
            bad++;
            $display("FAIL idle_after_reset got tl=%0d run=%b end=%b want 0", timeleft, running, end_f);
        end
    endtask

    task automatic test_oneshot();
        logic [4:0] etl;
        do_load(5'd5, 1'b0);
        total++;
        if (timeleft !== 5'd5 || running !== 1'b1 || warn !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_load got tl=%0d run=%b warn=%b want 5 1 0", timeleft, running, warn);
        end
        for (int e = 1; e <= 23; e++) begin
            step();
            etl = (e >= 20) ? 5'd0 : 5'(5 - e / 4);
            total++;
            if (timeleft !== etl || warn !== (e >= 8 && e <= 19) || expired !== (e == 20) ||
                end_f !== (e >= 20) || running !== (e < 20)) begin
                bad++;
                $display("FAIL oneshot_e%0d got tl=%0d warn=%b exp=%b end=%b run=%b want tl=%0d",
                         e, timeleft, warn, expired, end_f, running, etl);
            end
        end
    endtask

    task automatic test_pause();
        int c;
        logic [4:0] etl;
        do_load(5'd5, 1'b0);
        for (int e = 1; e <= 32; e++) begin
            if (e == 7)  pause = 1'b1;
            if (e == 17) pause = 1'b0;
            step();
            c = (e <= 7) ? e : ((e <= 17) ? 7 : e - 10);
            etl = (c >= 20) ? 5'd0 : 5'(5 - c / 4);
            total++;
            if (timeleft !== etl || expired !== (e == 30) || end_f !== (e >= 30) ||
                running !== (e < 30)) begin
                bad++;
                $display("FAIL pause_e%0d got tl=%0d exp=%b end=%b run=%b want tl=%0d exp=%b",
                         e, timeleft, expired, end_f, running, etl, e == 30);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_reload();
        logic [4:0] etl;
        do_load(5'd2, 1'b1);
        for (int e = 1; e <= 26; e++) begin
            step();
            etl = ((e / 4) % 2 == 0) ? 5'd2 : 5'd1;
            total++;
            if (timeleft !== etl || expired !== (e % 8 == 0) || end_f !== 1'b0 ||
                running !== 1'b1 || warn !== 1'b1) begin
                bad++;
                $display("FAIL reload_e%0d got tl=%0d exp=%b end=%b run=%b warn=%b want tl=%0d exp=%b",
                         e, timeleft, expired, end_f, running, warn, etl, e % 8 == 0);
            end
        end
    endtask

    task automatic test_zero_load();
        do_load(5'd0, 1'b0);
        total++;
        if (timeleft !== 5'd0 || end_f !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL zero_load got tl=%0d end=%b exp=%b run=%b want 0 1 1 0",
                     timeleft, end_f, expired, running);
        end
        pause = 1'b1;
        step(); step();
        pause = 1'b0;
        for (int e = 0; e < 6; e++) step();
        total++;
        if (timeleft !== 5'd0 || end_f !== 1'b1 || expired !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL zero_hold got tl=%0d end=%b exp=%b run=%b want 0 1 0 0",
                     timeleft, end_f, expired, running);
        end
    endtask

    task automatic test_load_on_tick();
        do_load(5'd1, 1'b0);
        step(); step(); step();
        load_value = 5'd7; load = 1'b1;
        step();
        load = 1'b0;
        total++;
        if (timeleft !== 5'd7 || expired !== 1'b0 || end_f !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL load_on_tick got tl=%0d exp=%b end=%b run=%b want 7 0 0 1",
                     timeleft, expired, end_f, running);
        end
        step(); step(); step();
        total++;
        if (timeleft !== 5'd7) begin
            bad++;
            $display("FAIL presc_restart_hold got tl=%0d want 7", timeleft);
        end
        step();
        total++;
        if (timeleft !== 5'd6 || expired !== 1'b0) begin
            bad++;
            $display("FAIL presc_restart_dec got tl=%0d exp=%b want 6 0", timeleft, expired);
        end
    endtask

    task automatic test_async_reset();
        do_load(5'd5, 1'b0);
        for (int e = 1; e <= 9; e++) step();
        total++;
        if (timeleft !== 5'd3 || warn !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got tl=%0d warn=%b want 3 1", timeleft, warn);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({timeleft, running, warn, end_f, expired} !== 9'b0) begin
            bad++;
            $display("FAIL async_reset got tl=%0d run=%b warn=%b end=%b exp=%b want all 0",
                     timeleft, running, warn, end_f, expired);
        end
        load_value = 5'd5; load = 1'b1;
        step();
        total++;
        if (timeleft !== 5'd0 || running !== 1'b0) begin
            bad++;
            $display("FAIL load_in_reset got tl=%0d run=%b want 0 0", timeleft, running);
        end
        load = 1'b0;
        #1 rst = 1'b0;
        for (int e = 0; e < 6; e++) step();
        total++;
        if ({timeleft, running, warn, end_f, expired} !== 9'b0) begin
            bad++;
            $display("FAIL idle_hold got tl=%0d run=%b end=%b want 0", timeleft, running, end_f);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_pause();
        test_reload();
        test_zero_load();
        test_load_on_tick();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
